// File: rtl/trig_arb_pkg.sv
// trig_arb_pkg
// Shared types and constants for the trigger stream arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OUT, HOLDOFF)
//   SRC_BEAM    : source tag value for the beam trigger stream
//   SRC_SOFT    : source tag value for the software/calibration stream
package trig_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OUT     = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_t;

  localparam logic SRC_BEAM = 1'b0;
  localparam logic SRC_SOFT = 1'b1;

endpackage

// File: rtl/trig_sat_counter.sv
// trig_sat_counter
// Event counter that adds 0, 1 or 2 per cycle and either wraps or
// saturates at all-ones on overflow.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (count -> 0)
//   clear : synchronous clear, takes priority over any increment
//   inc   : increment amount this cycle (0..2)
//   count : current count
module trig_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  // One extra bit so an overflow past all-ones is visible for saturation.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, count} + {{(WIDTH - 1){1'b0}}, inc};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (SATURATE && sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/trig_stream_arbiter.sv
// trig_stream_arbiter
// Merges the beam trigger stream and the software/calibration trigger
// stream onto one trigger AXI4-Stream link. Sources are served round-robin
// when both are valid, a programmable number of dead cycles follows each
// issued trigger, and while the run is stopped every input beat is accepted
// and discarded (and counted).
// Ports:
//   ifclk        : sole clock
//   rst_i        : synchronous active-high reset
//   runrst_i     : start-of-run pulse, clears both counters
//   runstop_i    : stop-of-run pulse (wins over runrst_i)
//   holdoff_i    : dead cycles after each issued trigger (quasi-static)
//   beam_*       : beam trigger input stream
//   soft_*       : software trigger input stream
//   trig_*       : merged trigger output stream, bit SRC_BIT carries source
//   running_o    : run active
//   trig_count_o : triggers issued this run (wraps)
//   drop_count_o : beats discarded while stopped (saturates)
module trig_stream_arbiter
  import trig_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int SRC_BIT       = 31,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     ifclk,
  input  logic                     rst_i,
  input  logic                     runrst_i,
  input  logic                     runstop_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  input  logic [DATA_WIDTH-1:0]    beam_tdata,
  input  logic                     beam_tvalid,
  output logic                     beam_tready,
  input  logic [DATA_WIDTH-1:0]    soft_tdata,
  input  logic                     soft_tvalid,
  output logic                     soft_tready,
  output logic [DATA_WIDTH-1:0]    trig_tdata,
  output logic                     trig_tvalid,
  input  logic                     trig_tready,
  output logic                     running_o,
  output logic [31:0]              trig_count_o,
  output logic [15:0]              drop_count_o
);

  arb_state_t              state;
  arb_state_t              next_state;
  logic                    rr_ptr;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt;
  logic                    grant_beam;
  logic                    grant_soft;
  logic                    out_hs;
  logic [DATA_WIDTH-1:0]   granted_word;
  logic [1:0]              drop_inc;

  // State register.
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Grants only happen while running; an in-flight beat
  // or holdoff always runs to completion regardless of run state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (running_o && (beam_tvalid || soft_tvalid)) begin
          next_state = OUT;
        end
      end
      OUT: begin
        if (trig_tready) begin
          next_state = (holdoff_i == '0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hold_cnt <= HOLDOFF_WIDTH'(1)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic. While stopped both inputs are drained unconditionally;
  // while running only the granted source sees tready, and only in IDLE.
  // On a tie the source named by rr_ptr wins.
  always_comb begin
    grant_beam = 1'b0;
    grant_soft = 1'b0;
    if (state == IDLE && running_o) begin
      grant_soft = soft_tvalid && (!beam_tvalid || rr_ptr == SRC_SOFT);
      grant_beam = beam_tvalid && !grant_soft;
    end
    beam_tready = !running_o || grant_beam;
    soft_tready = !running_o || grant_soft;
    out_hs      = (state == OUT) && trig_tready;
  end

  // Granted word with the source tag overlaid on SRC_BIT.
  always_comb begin
    granted_word          = grant_soft ? soft_tdata : beam_tdata;
    granted_word[SRC_BIT] = grant_soft ? SRC_SOFT : SRC_BEAM;
  end

  // Discarded beats: each valid input counts one since tready is forced high.
  always_comb begin
    drop_inc = 2'd0;
    if (!running_o) begin
      drop_inc = {1'b0, beam_tvalid} + {1'b0, soft_tvalid};
    end
  end

  // Run flag: stop takes priority over start.
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      running_o <= 1'b0;
    end else if (runstop_i) begin
      running_o <= 1'b0;
    end else if (runrst_i) begin
      running_o <= 1'b1;
    end
  end

  // Output register, round-robin pointer and holdoff counter. The pointer
  // only moves on a contested grant so a lone source never loses its turn.
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      trig_tvalid <= 1'b0;
      trig_tdata  <= '0;
      rr_ptr      <= SRC_BEAM;
      hold_cnt    <= '0;
    end else begin
      if (grant_beam || grant_soft) begin
        trig_tvalid <= 1'b1;
        trig_tdata  <= granted_word;
        if (beam_tvalid && soft_tvalid) begin
          rr_ptr <= ~rr_ptr;
        end
      end else if (out_hs) begin
        trig_tvalid <= 1'b0;
      end

      if (out_hs) begin
        hold_cnt <= holdoff_i;
      end else if (state == HOLDOFF) begin
        hold_cnt <= hold_cnt - HOLDOFF_WIDTH'(1);
      end
    end
  end

  trig_sat_counter #(
    .WIDTH    (32),
    .SATURATE (1'b0)
  ) u_trig_count (
    .clk   (ifclk),
    .rst   (rst_i),
    .clear (runrst_i),
    .inc   ({1'b0, out_hs}),
    .count (trig_count_o)
  );

  trig_sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b1)
  ) u_drop_count (
    .clk   (ifclk),
    .rst   (rst_i),
    .clear (runrst_i),
    .inc   (drop_inc),
    .count (drop_count_o)
  );

endmodule
